apb_reg_bridge: RTL and testbench
=================================

APB_REG_BRIDGE -- requirements
Module: apb_reg_bridge

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, extra pready delay cycles (legal 0..15).
REQ-002 SHALL have parameter ADDR_MAX, default 12'h1C, highest legal word address.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port psel  input  1  APB select.
REQ-006 SHALL have port penable  input  1  APB access phase.
REQ-007 SHALL have port pwrite  input  1  APB direction, 1 = write.
REQ-008 SHALL have port paddr  input  12  APB byte address.
REQ-009 SHALL have port pwdata  input  32  APB write data.
REQ-010 SHALL have port prdata  output  32  APB read data.
REQ-011 SHALL have port pready  output  1  APB transfer complete.
REQ-012 SHALL have port pslverr  output  1  APB error, valid with pready.
REQ-013 SHALL have port wr_en  output  1  register-bank write strobe.
REQ-014 SHALL have port rd_en  output  1  register-bank read strobe.
REQ-015 SHALL have port addr  output  12  register-bank address, the captured paddr.
REQ-016 SHALL have port wr_data  output  32  register-bank write data, the captured pwdata.
REQ-017 SHALL have port rd_data  input  32  register-bank read data, combinational from the bank.

Function
REQ-018 SHALL implement the FSM states IDLE, SETUP, WAIT and RESP, held in a state register.
REQ-019 IDLE SHALL move to SETUP on psel=1 & penable=0, capturing paddr, pwrite and pwdata.
REQ-020 IDLE SHALL ignore psel=1 & penable=1, so a transfer without a setup phase is never accepted.
REQ-021 SETUP SHALL move on psel & penable to RESP if WAIT_STATES=0, else to WAIT with a counter loaded with WAIT_STATES.
REQ-022 SETUP SHALL stay in SETUP and recapture on psel & ~penable, and SHALL return to IDLE on ~psel.
REQ-023 WAIT SHALL decrement the counter each cycle and move to RESP when the counter equals 1.
REQ-024 WAIT SHALL abort to IDLE on ~psel, with no strobe and no pready.
REQ-025 RESP SHALL last exactly one cycle and then move to IDLE unconditionally.
REQ-026 With the setup phase in cycle 0 and the access phase from cycle 1, pready SHALL be high in cycle 2+WAIT_STATES only.
REQ-027 pready SHALL be high if and only if state=RESP.
REQ-028 An error SHALL be the captured address having addr[1:0]!=0 or addr>ADDR_MAX.
REQ-029 pslverr SHALL be high if and only if state=RESP and there is an error.
REQ-030 wr_en SHALL be high for exactly the RESP cycle when the captured pwrite=1 and there is no error.
REQ-031 rd_en SHALL be high for exactly the RESP cycle when the captured pwrite=0 and there is no error.
REQ-032 prdata SHALL equal rd_data when rd_en=1, and SHALL be 32'h0 at all other times.
REQ-033 addr and wr_data SHALL hold the captured values stable from SETUP through RESP.
REQ-034 Back-to-back transfers SHALL be supported: a setup phase in the cycle after RESP is accepted by IDLE with no lost cycle.
REQ-035 At most one wr_en or rd_en pulse SHALL occur per APB transfer.

Reset
REQ-036 On rst_n=0, state SHALL become IDLE and the counter 0, asynchronously.
REQ-037 On rst_n=0, addr and wr_data SHALL become 0, asynchronously.
REQ-038 On rst_n=0, pready, pslverr, wr_en, rd_en and prdata SHALL become 0, asynchronously.
REQ-039 Reset asserted mid-transfer SHALL abort the transfer with no wr_en and no pready.
REQ-040 After reset release, the bridge SHALL wait for a fresh setup phase.

Verification
REQ-041 Zero-wait write, WAIT_STATES=0, paddr=12'h18, pwdata=32'h1 -> wr_en=1 and pready=1 in cycle 2, addr=12'h18, wr_data=32'h1, pslverr=0.
REQ-042 Read with WAIT_STATES=3, paddr=12'h18, rd_data=32'h1 -> pready in cycle 5 only, prdata=32'h1, rd_en pulses once, prdata=32'h0 in cycle 6.
REQ-043 Error cases paddr=12'h1A and paddr=12'h20 -> pready=1 and pslverr=1, wr_en=0, rd_en=0, prdata=32'h0.
REQ-044 psel dropped in cycle 3 of a WAIT_STATES=3 write -> return to IDLE, no wr_en, no pready, next transfer normal.
REQ-045 Back-to-back write 12'h18 then read 12'h18 -> two pready pulses 3 cycles apart (WAIT_STATES=0), one wr_en, one rd_en.
REQ-046 rst_n pulsed low during WAIT -> all outputs 0 immediately, no wr_en after release.

Source files
------------

// File: rtl/apb_reg_bridge.sv
// APB slave front-end that turns APB transfers into single-cycle register-bank
// read/write strobes, with a fixed number of optional wait states and address
// range/alignment error reporting.
module apb_reg_bridge #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [11:0] ADDR_MAX    = 12'h1C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [11:0] addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    state_t     state;
    logic [3:0] cnt;
    logic       pwrite_q;
    logic       err;
    logic       to_resp;

    assign err = (addr[1:0] != 2'b00) || (addr > ADDR_MAX);

    assign to_resp = ((state == SETUP) && psel && penable && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && psel && (cnt == 4'd1));

    assign prdata = rd_en ? rd_data : '0;

    // Transfer FSM with captured request and registered response/strobe outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= '0;
            wr_data  <= '0;
            pwrite_q <= 1'b0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
        end else begin
            pready  <= to_resp;
            pslverr <= to_resp && err;
            wr_en   <= to_resp && pwrite_q && !err;
            rd_en   <= to_resp && !pwrite_q && !err;
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        state    <= SETUP;
                        addr     <= paddr;
                        wr_data  <= pwdata;
                        pwrite_q <= pwrite;
                    end
                end
                SETUP: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (penable) begin
                        state <= (WAIT_STATES == 0) ? RESP : WAIT;
                        cnt   <= WS4;
                    end else begin
                        addr     <= paddr;
                        wr_data  <= pwdata;
                        pwrite_q <= pwrite;
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed bench for apb_reg_bridge: one zero-wait and one three-wait-state
// instance share the APB inputs; each step checks the instance it targets.
module tb_apb_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, rd_data;

    logic [31:0] p0_prdata, p3_prdata;
    logic        p0_pready, p0_pslverr, p0_wr_en, p0_rd_en;
    logic        p3_pready, p3_pslverr, p3_wr_en, p3_rd_en;
    logic [11:0] p0_addr, p3_addr;
    logic [31:0] p0_wr_data, p3_wr_data;

    int checks   = 0;
    int failures = 0;
    int n_pr, n_wr, n_rd;

    always #5 clk = ~clk;

    apb_reg_bridge #(.WAIT_STATES(0), .ADDR_MAX(12'h1C)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(p0_prdata), .pready(p0_pready),
        .pslverr(p0_pslverr), .wr_en(p0_wr_en), .rd_en(p0_rd_en), .addr(p0_addr),
        .wr_data(p0_wr_data), .rd_data(rd_data)
    );

    apb_reg_bridge #(.WAIT_STATES(3), .ADDR_MAX(12'h1C)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(p3_prdata), .pready(p3_pready),
        .pslverr(p3_pslverr), .wr_en(p3_wr_en), .rd_en(p3_rd_en), .addr(p3_addr),
        .wr_data(p3_wr_data), .rd_data(rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a new cycle: inputs change 1 time unit after the rising edge
    task automatic drive(input logic s, input logic e, input logic w,
                         input logic [11:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        psel    = s;
        penable = e;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        rd_data = 32'hFFFF_FFFF;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pready",  {31'b0, p0_pready},  32'h0);
        chk("rst_pslverr", {31'b0, p0_pslverr}, 32'h0);
        chk("rst_wr_en",   {31'b0, p0_wr_en},   32'h0);
        chk("rst_rd_en",   {31'b0, p3_rd_en},   32'h0);
        chk("rst_prdata",  p0_prdata,           32'h0);
        chk("rst_addr",    {20'b0, p3_addr},    32'h0);
        chk("rst_wr_data", p3_wr_data,          32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Zero-wait write to 0x18
        drive(1'b1, 1'b0, 1'b1, 12'h018, 32'h1);
        @(negedge clk);
        chk("t1_c0_pready", {31'b0, p0_pready}, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h1);
        @(negedge clk);
        chk("t1_c1_pready",  {31'b0, p0_pready}, 32'h0);
        chk("t1_c1_wr_en",   {31'b0, p0_wr_en},  32'h0);
        chk("t1_c1_addr",    {20'b0, p0_addr},   32'h18);
        chk("t1_c1_wr_data", p0_wr_data,         32'h1);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h1);
        @(negedge clk);
        chk("t1_c2_pready",  {31'b0, p0_pready},  32'h1);
        chk("t1_c2_wr_en",   {31'b0, p0_wr_en},   32'h1);
        chk("t1_c2_rd_en",   {31'b0, p0_rd_en},   32'h0);
        chk("t1_c2_pslverr", {31'b0, p0_pslverr}, 32'h0);
        chk("t1_c2_addr",    {20'b0, p0_addr},    32'h18);
        chk("t1_c2_wr_data", p0_wr_data,          32'h1);
        idle(1);
        @(negedge clk);
        chk("t1_c3_pready", {31'b0, p0_pready}, 32'h0);
        chk("t1_c3_wr_en",  {31'b0, p0_wr_en},  32'h0);
        idle(1);

        // Three-wait-state read of 0x18
        rd_data = 32'h1;
        n_rd = 0;
        drive(1'b1, 1'b0, 1'b0, 12'h018, 32'h0);
        @(negedge clk);
        n_rd += int'(p3_rd_en);
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 1'b1, 1'b0, 12'h018, 32'h0);
            @(negedge clk);
            chk("t2_wait_pready", {31'b0, p3_pready}, 32'h0);
            chk("t2_wait_prdata", p3_prdata,          32'h0);
            chk("t2_wait_addr",   {20'b0, p3_addr},   32'h18);
            n_rd += int'(p3_rd_en);
            if (c == 2) chk("t2_ws0_rd_prdata", p0_prdata, 32'h1);
        end
        drive(1'b1, 1'b1, 1'b0, 12'h018, 32'h0);
        @(negedge clk);
        chk("t2_c5_pready",  {31'b0, p3_pready},  32'h1);
        chk("t2_c5_rd_en",   {31'b0, p3_rd_en},   32'h1);
        chk("t2_c5_wr_en",   {31'b0, p3_wr_en},   32'h0);
        chk("t2_c5_pslverr", {31'b0, p3_pslverr}, 32'h0);
        chk("t2_c5_prdata",  p3_prdata,           32'h1);
        n_rd += int'(p3_rd_en);
        idle(1);
        @(negedge clk);
        chk("t2_c6_pready", {31'b0, p3_pready}, 32'h0);
        chk("t2_c6_prdata", p3_prdata,          32'h0);
        n_rd += int'(p3_rd_en);
        chk("t2_rd_pulses", 32'(n_rd), 32'd1);
        idle(1);

        // Error responses: misaligned write, out-of-range read, and the last legal word
        rd_data = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 1'b1, 12'h01A, 32'hA5A5_A5A5);
        drive(1'b1, 1'b1, 1'b1, 12'h01A, 32'hA5A5_A5A5);
        drive(1'b1, 1'b1, 1'b1, 12'h01A, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("t3a_pready",  {31'b0, p0_pready},  32'h1);
        chk("t3a_pslverr", {31'b0, p0_pslverr}, 32'h1);
        chk("t3a_wr_en",   {31'b0, p0_wr_en},   32'h0);
        chk("t3a_rd_en",   {31'b0, p0_rd_en},   32'h0);
        chk("t3a_prdata",  p0_prdata,           32'h0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 12'h020, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 12'h020, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 12'h020, 32'h0);
        @(negedge clk);
        chk("t3b_pready",  {31'b0, p0_pready},  32'h1);
        chk("t3b_pslverr", {31'b0, p0_pslverr}, 32'h1);
        chk("t3b_wr_en",   {31'b0, p0_wr_en},   32'h0);
        chk("t3b_rd_en",   {31'b0, p0_rd_en},   32'h0);
        chk("t3b_prdata",  p0_prdata,           32'h0);
        idle(2);
        drive(1'b1, 1'b0, 1'b0, 12'h01C, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 12'h01C, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 12'h01C, 32'h0);
        @(negedge clk);
        chk("t3c_pready",  {31'b0, p0_pready},  32'h1);
        chk("t3c_pslverr", {31'b0, p0_pslverr}, 32'h0);
        chk("t3c_rd_en",   {31'b0, p0_rd_en},   32'h1);
        chk("t3c_prdata",  p0_prdata,           32'hFFFF_FFFF);
        idle(2);

        // psel dropped in cycle 3 of a three-wait-state write, then a normal write
        n_pr = 0;
        n_wr = 0;
        drive(1'b1, 1'b0, 1'b1, 12'h018, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'hDEAD_BEEF);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'hDEAD_BEEF);
        for (int c = 3; c <= 6; c++) begin
            idle(1);
            @(negedge clk);
            n_pr += int'(p3_pready);
            n_wr += int'(p3_wr_en);
        end
        chk("t4_abort_pready", 32'(n_pr), 32'd0);
        chk("t4_abort_wr_en",  32'(n_wr), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 12'h014, 32'h0000_0055);
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 1'b1, 1'b1, 12'h014, 32'h0000_0055);
            @(negedge clk);
            chk("t4_wait_pready", {31'b0, p3_pready}, 32'h0);
        end
        drive(1'b1, 1'b1, 1'b1, 12'h014, 32'h0000_0055);
        @(negedge clk);
        chk("t4_next_pready",  {31'b0, p3_pready}, 32'h1);
        chk("t4_next_wr_en",   {31'b0, p3_wr_en},  32'h1);
        chk("t4_next_addr",    {20'b0, p3_addr},   32'h14);
        chk("t4_next_wr_data", p3_wr_data,         32'h0000_0055);
        idle(2);

        // Back-to-back zero-wait write then read of 0x18
        rd_data = 32'h0000_0007;
        n_pr = 0;
        n_wr = 0;
        n_rd = 0;
        drive(1'b1, 1'b0, 1'b1, 12'h018, 32'h0000_0007);
        @(negedge clk);
        n_pr += int'(p0_pready); n_wr += int'(p0_wr_en); n_rd += int'(p0_rd_en);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h0000_0007);
        @(negedge clk);
        n_pr += int'(p0_pready); n_wr += int'(p0_wr_en); n_rd += int'(p0_rd_en);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h0000_0007);
        @(negedge clk);
        chk("t5_c2_wr_en", {31'b0, p0_wr_en}, 32'h1);
        n_pr += int'(p0_pready); n_wr += int'(p0_wr_en); n_rd += int'(p0_rd_en);
        drive(1'b1, 1'b0, 1'b0, 12'h018, 32'h0);
        @(negedge clk);
        chk("t5_c3_pready", {31'b0, p0_pready}, 32'h0);
        n_pr += int'(p0_pready); n_wr += int'(p0_wr_en); n_rd += int'(p0_rd_en);
        drive(1'b1, 1'b1, 1'b0, 12'h018, 32'h0);
        @(negedge clk);
        chk("t5_c4_pready", {31'b0, p0_pready}, 32'h0);
        n_pr += int'(p0_pready); n_wr += int'(p0_wr_en); n_rd += int'(p0_rd_en);
        drive(1'b1, 1'b1, 1'b0, 12'h018, 32'h0);
        @(negedge clk);
        chk("t5_c5_pready", {31'b0, p0_pready}, 32'h1);
        chk("t5_c5_rd_en",  {31'b0, p0_rd_en},  32'h1);
        chk("t5_c5_prdata", p0_prdata,          32'h0000_0007);
        n_pr += int'(p0_pready); n_wr += int'(p0_wr_en); n_rd += int'(p0_rd_en);
        idle(1);
        @(negedge clk);
        n_pr += int'(p0_pready); n_wr += int'(p0_wr_en); n_rd += int'(p0_rd_en);
        chk("t5_pready_pulses", 32'(n_pr), 32'd2);
        chk("t5_wr_pulses",     32'(n_wr), 32'd1);
        chk("t5_rd_pulses",     32'(n_rd), 32'd1);
        idle(2);

        // Reset pulse while the wait-state instance is in WAIT and the zero-wait one in RESP
        drive(1'b1, 1'b0, 1'b1, 12'h018, 32'h0000_1234);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h0000_1234);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h0000_1234);
        #2;
        chk("t6_pre_pready", {31'b0, p0_pready}, 32'h1);
        chk("t6_pre_addr",   {20'b0, p3_addr},   32'h18);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pready",  {31'b0, p0_pready},  32'h0);
        chk("t6_rst_wr_en",   {31'b0, p0_wr_en},   32'h0);
        chk("t6_rst_addr0",   {20'b0, p0_addr},    32'h0);
        chk("t6_rst_addr3",   {20'b0, p3_addr},    32'h0);
        chk("t6_rst_wdata3",  p3_wr_data,          32'h0);
        n_pr = 0;
        n_wr = 0;
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h0000_1234);
        drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h0000_1234);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_pr += int'(p3_pready) + int'(p0_pready);
            n_wr += int'(p3_wr_en) + int'(p0_wr_en);
            drive(1'b1, 1'b1, 1'b1, 12'h018, 32'h0000_1234);
        end
        chk("t6_post_pready", 32'(n_pr), 32'd0);
        chk("t6_post_wr_en",  32'(n_wr), 32'd0);
        idle(1);
        drive(1'b1, 1'b0, 1'b1, 12'h010, 32'h0000_00AA);
        drive(1'b1, 1'b1, 1'b1, 12'h010, 32'h0000_00AA);
        drive(1'b1, 1'b1, 1'b1, 12'h010, 32'h0000_00AA);
        @(negedge clk);
        chk("t6_fresh_wr_en",   {31'b0, p0_wr_en}, 32'h1);
        chk("t6_fresh_wr_data", p0_wr_data,        32'h0000_00AA);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
